// File: rtl/clock_divider_if.sv
// Control and output bundle of the clock divider: enable, divide ratio and
// the resulting divided clock.
interface clock_divider_if #(
  parameter int RATIO_WIDTH = 8
);
  logic                   i_clk_en;
  logic [RATIO_WIDTH-1:0] i_div_ratio;
  logic                   o_div_clk;

  modport master (
    output i_clk_en,
    output i_div_ratio,
    input  o_div_clk
  );

  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    output o_div_clk
  );
endinterface

// File: rtl/clock_divider.sv
// Integer clock divider: divides i_ref_clk by a run-time ratio N, or passes
// i_ref_clk straight through when disabled or when N is 0 or 1.
module clock_divider #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  clock_divider_if.slave   bus
);

  logic                   divide_s;
  logic [RATIO_WIDTH-1:0] half_len_s;
  logic [RATIO_WIDTH-1:0] low_len_s;
  logic [RATIO_WIDTH:0]   phase_len_s;
  logic [RATIO_WIDTH:0]   cnt_next_s;
  logic [RATIO_WIDTH-1:0] cnt_r;
  logic                   div_r;

  // Mode select and length of the phase currently in progress
  always_comb begin
    divide_s    = 1'b0;
    half_len_s  = bus.i_div_ratio >> 1;
    low_len_s   = half_len_s + {{(RATIO_WIDTH-1){1'b0}}, bus.i_div_ratio[0]};
    phase_len_s = {1'b0, low_len_s};
    cnt_next_s  = {1'b0, cnt_r} + {{RATIO_WIDTH{1'b0}}, 1'b1};
    if (bus.i_clk_en && (bus.i_div_ratio >= RATIO_WIDTH'(2))) begin
      divide_s = 1'b1;
    end else begin
      divide_s = 1'b0;
    end
    // Low phase takes the extra cycle for odd ratios
    if (div_r) begin
      phase_len_s = {1'b0, half_len_s};
    end else begin
      phase_len_s = {1'b0, low_len_s};
    end
  end

  // Phase counter and divided-clock register; ">=" ends a phase at once if N shrinks below the count
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      cnt_r <= {RATIO_WIDTH{1'b0}};
      div_r <= 1'b0;
    end else if (!divide_s) begin
      cnt_r <= {RATIO_WIDTH{1'b0}};
      div_r <= 1'b0;
    end else if (cnt_next_s >= phase_len_s) begin
      cnt_r <= {RATIO_WIDTH{1'b0}};
      div_r <= ~div_r;
    end else begin
      cnt_r <= cnt_next_s[RATIO_WIDTH-1:0];
      div_r <= div_r;
    end
  end

  // Bypass hands out the reference clock itself through a plain mux
  always_comb begin
    if (divide_s) begin
      bus.o_div_clk = div_r;
    end else begin
      bus.o_div_clk = i_ref_clk;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: divide ratios, bypass, ratio change,
// mid-operation reset and the maximum ratio.
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  clock_divider_if #(.RATIO_WIDTH(8)) bus ();

  clock_divider #(.RATIO_WIDTH(8)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // After a fresh start (state cleared), edge k shows high when (k mod N) >= low length
  task automatic run_div(input int n, input int low, input int cycles);
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("div%0d_e%0d", n, k), bus.o_div_clk, logic'((k % n) >= low));
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(tag, bus.o_div_clk, 1'b0);
    rst = 1'b0;
  endtask

  task automatic check_bypass(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("%s_lo%0d", tag, i), bus.o_div_clk, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("%s_hi%0d", tag, i), bus.o_div_clk, 1'b1);
    end
  endtask

  logic [9:0] chg_seq;

  initial begin
    rst             = 1'b1;
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd2;
    @(posedge clk);
    #1;
    do_reset("reset_n2");
    run_div(2, 1, 10);

    bus.i_div_ratio = 8'd3;
    do_reset("reset_n3");
    run_div(3, 2, 9);

    bus.i_div_ratio = 8'd7;
    do_reset("reset_n7");
    run_div(7, 4, 21);

    bus.i_div_ratio = 8'd4;
    do_reset("reset_n4");
    run_div(4, 2, 12);

    bus.i_div_ratio = 8'd6;
    do_reset("reset_n6");
    run_div(6, 3, 18);

    // 5 -> 4 during the low phase after two low edges
    bus.i_div_ratio = 8'd5;
    do_reset("reset_n5chg");
    run_div(5, 3, 2);
    bus.i_div_ratio = 8'd4;
    chg_seq = 10'b1100110011;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("chg5to4_e%0d", i + 3), bus.o_div_clk, chg_seq[9-i]);
    end

    // Bypass cases
    bus.i_div_ratio = 8'd0;
    check_bypass("byp_n0", 3);
    bus.i_div_ratio = 8'd1;
    check_bypass("byp_n1", 3);
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = 8'd2;
    check_bypass("byp_en0", 3);

    // Re-enable with N=5: output drops to 0 while ref clock is still high
    bus.i_clk_en    = 1'b1;
    bus.i_div_ratio = 8'd5;
    #1;
    check("reenable_drop", bus.o_div_clk, 1'b0);
    run_div(5, 3, 10);

    // Reset during the high phase of N=5
    run_div(5, 3, 3);
    do_reset("reset_mid_high");
    run_div(5, 3, 10);

    bus.i_div_ratio = 8'd255;
    do_reset("reset_n255");
    run_div(255, 128, 510);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
